// File: rtl/spiflash_rd_master.sv
// SPI mode-0 flash READ initiator: word bursts in, little-endian 32-bit words out.
// Define SPIFLASH_RD_FAST_EN to use FAST READ (0x0B) with 8 dummy bit cells.
`timescale 1ns/1ps
module spiflash_rd_master #(
  parameter int CLK_DIV = 2
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        csb,
  output logic        spiclk,
  output logic        io0,
  input  logic        io1
);

`ifdef SPIFLASH_RD_FAST_EN
  localparam logic [7:0] RD_CMD = 8'h0B;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_END, ST_GAP} state_t;
`else
  localparam logic [7:0] RD_CMD = 8'h03;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_END, ST_GAP} state_t;
`endif

  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

  state_t      state_r;
  logic [8:0]  cnt_r;
  logic [4:0]  bit_cnt_r;
  logic [7:0]  words_left_r;
  logic [31:0] tx_r;
  logic [31:0] rx_r;
  logic        word_rdy_r;
  logic [31:0] rd_data_r;
  logic        rd_valid_r;
  logic        busy_r;
  logic        csb_r;
  logic        spiclk_r;
  logic        io0_r;

  logic half_done_s;
  logic move_s;
  logic stall_s;

  // rx_r holds the first byte in its top bits; reorder so byte k sits at [8k+7:8k]
  function automatic logic [31:0] le_word(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign half_done_s = (cnt_r == HALF_LAST);
  assign move_s      = word_rdy_r && (!rd_valid_r || rd_ready);
  // A completed word still waiting for the output register freezes the next bit cell
  assign stall_s     = (state_r == ST_DATA) && word_rdy_r;

  assign req_ready = (state_r == ST_IDLE) && !rd_valid_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign busy      = busy_r;
  assign csb       = csb_r;
  assign spiclk    = spiclk_r;
  assign io0       = io0_r;

  // Transaction FSM, bit-cell timing, word assembly and output handoff
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 9'd0;
      bit_cnt_r    <= 5'd0;
      words_left_r <= 8'd0;
      tx_r         <= 32'd0;
      rx_r         <= 32'd0;
      word_rdy_r   <= 1'b0;
      rd_data_r    <= 32'd0;
      rd_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      csb_r        <= 1'b1;
      spiclk_r     <= 1'b0;
      io0_r        <= 1'b0;
    end else begin
      if (move_s) begin
        rd_data_r  <= le_word(rx_r);
        rd_valid_r <= 1'b1;
        word_rdy_r <= 1'b0;
      end else if (rd_valid_r && rd_ready) begin
        rd_valid_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            state_r      <= ST_CMD;
            tx_r         <= {RD_CMD, req_addr & 24'hFF_FFFC};
            words_left_r <= req_len;
            io0_r        <= RD_CMD[7];
            csb_r        <= 1'b0;
            busy_r       <= 1'b1;
            spiclk_r     <= 1'b0;
            cnt_r        <= 9'd0;
            bit_cnt_r    <= 5'd0;
          end
        end
        ST_END: begin
          if (!word_rdy_r) begin
            if (half_done_s) begin
              csb_r   <= 1'b1;
              state_r <= ST_GAP;
              cnt_r   <= 9'd0;
            end else begin
              cnt_r <= cnt_r + 9'd1;
            end
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= 9'd0;
          end else begin
            cnt_r <= cnt_r + 9'd1;
          end
        end
        default: begin
          if (!spiclk_r) begin
            if (stall_s) begin
              cnt_r <= cnt_r;
            end else if (half_done_s) begin
              spiclk_r <= 1'b1;
              cnt_r    <= 9'd0;
              if (state_r == ST_DATA) begin
                rx_r <= {rx_r[30:0], io1};
                if (bit_cnt_r == 5'd31) begin
                  word_rdy_r <= 1'b1;
                end
              end
            end else begin
              cnt_r <= cnt_r + 9'd1;
            end
          end else if (half_done_s) begin
            // Falling edge: the next bit cell's low phase starts and io0 advances
            spiclk_r  <= 1'b0;
            cnt_r     <= 9'd0;
            bit_cnt_r <= bit_cnt_r + 5'd1;
            tx_r      <= {tx_r[30:0], 1'b0};
            io0_r     <= tx_r[30];
            case (state_r)
              ST_CMD: begin
                if (bit_cnt_r == 5'd7) begin
                  state_r   <= ST_ADDR;
                  bit_cnt_r <= 5'd0;
                end
              end
              ST_ADDR: begin
                if (bit_cnt_r == 5'd23) begin
`ifdef SPIFLASH_RD_FAST_EN
                  state_r   <= ST_DUMMY;
`else
                  state_r   <= ST_DATA;
`endif
                  bit_cnt_r <= 5'd0;
                  io0_r     <= 1'b0;
                end
              end
`ifdef SPIFLASH_RD_FAST_EN
              ST_DUMMY: begin
                io0_r <= 1'b0;
                if (bit_cnt_r == 5'd7) begin
                  state_r   <= ST_DATA;
                  bit_cnt_r <= 5'd0;
                end
              end
`endif
              ST_DATA: begin
                io0_r <= 1'b0;
                if (bit_cnt_r == 5'd31) begin
                  if (words_left_r == 8'd0) begin
                    state_r <= ST_END;
                  end else begin
                    words_left_r <= words_left_r - 8'd1;
                  end
                end
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end else begin
            cnt_r <= cnt_r + 9'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spiflash_rd_master.sv
// Self-checking bench for spiflash_rd_master with a behavioural mode-0 flash responder.
`timescale 1ns/1ps
module tb_spiflash_rd_master;
  localparam int CLK_DIV = 2;
`ifdef SPIFLASH_RD_FAST_EN
  localparam int         HDR     = 40;
  localparam logic [7:0] EXP_CMD = 8'h0B;
`else
  localparam int         HDR     = 32;
  localparam logic [7:0] EXP_CMD = 8'h03;
`endif
  localparam int DUMMY_RISES = HDR - 32;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = 24'd0;
  logic [7:0]  req_len = 8'd0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        busy;
  logic        csb;
  logic        spiclk;
  logic        io0;
  logic        io1 = 1'b0;

  spiflash_rd_master #(.CLK_DIV(CLK_DIV)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .csb(csb), .spiclk(spiclk), .io0(io0), .io1(io1)
  );

  always #5 ap_clk = ~ap_clk;

  // Flash responder: shifts in command+address on rises, drives data on falls
  logic [7:0]  mem [0:255];
  logic [31:0] sh_r = 32'd0;
  logic [31:0] hdr_r = 32'd0;
  int          sbits = 0;

  function automatic logic flash_bit(input logic [7:0] base, input int idx);
    logic [7:0] b;
    b = mem[base + 8'(idx / 8)];
    return b[3'(7 - (idx % 8))];
  endfunction

  always @(posedge spiclk or posedge csb) begin
    if (csb) begin
      sbits <= 0;
    end else begin
      sh_r <= {sh_r[30:0], io0};
      if (sbits == 31) hdr_r <= {sh_r[30:0], io0};
      sbits <= sbits + 1;
    end
  end

  always @(negedge spiclk) begin
    if (!csb && sbits >= HDR) io1 <= flash_bit(hdr_r[7:0], sbits - HDR);
  end

  // Edge/latency monitor sampled on the inactive clock edge
  int   cyc = 0, rises = 0, csb_falls = 0, gap_cnt = 0;
  int   fall_cyc = 0, first_rise_cyc = 0, last_rise_cyc = 0, rdv_cyc = 0;
  logic spk_p = 1'b0, csb_p = 1'b1, rdv_p = 1'b0, want_first = 1'b0;

  always @(negedge ap_clk) begin
    cyc   <= cyc + 1;
    spk_p <= spiclk;
    csb_p <= csb;
    rdv_p <= rd_valid;
    if (!csb && csb_p) begin
      csb_falls  <= csb_falls + 1;
      fall_cyc   <= cyc;
      want_first <= 1'b1;
    end
    if (spiclk && !spk_p) begin
      rises         <= rises + 1;
      last_rise_cyc <= cyc;
      if (want_first) begin
        first_rise_cyc <= cyc;
        want_first     <= 1'b0;
      end
    end
    if (rd_valid && !rdv_p) rdv_cyc <= cyc;
    if (csb && busy) gap_cnt <= gap_cnt + 1;
  end

  int          errs = 0, checks = 0;
  logic [31:0] got_w [0:3];
  int          got_n = 0;

  typedef struct packed {
    logic [23:0]       addr;
    logic [7:0]        len;
    logic [23:0]       exp_addr;
    logic [3:0][31:0]  w;
    logic [31:0]       rises;
  } vec_t;

  vec_t vecs [0:4];
  vec_t v20;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic start_req(input logic [23:0] a, input logic [7:0] l);
    int t;
    t = 0;
    while (!req_ready && t < 2000) begin
      @(negedge ap_clk);
      t++;
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    @(negedge ap_clk);
    req_valid = 1'b0;
    chk("accept_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic collect(input int n, input int budget);
    int t;
    t = 0;
    got_n = 0;
    while (t < budget && !(got_n >= n && !busy && !rd_valid)) begin
      if (rd_valid && rd_ready) begin
        if (got_n < 4) got_w[got_n] = rd_data;
        got_n++;
      end
      @(negedge ap_clk);
      t++;
    end
    if (t >= budget) begin
      checks++;
      errs++;
      $display("FAIL collect_timeout: got %0d words after %0d cycles, required %0d", got_n, t, n);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int r0, f0, g0;
    r0 = rises; f0 = csb_falls; g0 = gap_cnt;
    rd_ready = 1'b1;
    start_req(v.addr, v.len);
    collect(int'(v.len) + 1, 4000);
    repeat (2) @(negedge ap_clk);
    chk($sformatf("v%0d_cmd", id), {24'd0, hdr_r[31:24]}, {24'd0, EXP_CMD});
    chk($sformatf("v%0d_addr", id), {8'd0, hdr_r[23:0]}, {8'd0, v.exp_addr});
    chk($sformatf("v%0d_nwords", id), 32'(got_n), 32'(int'(v.len) + 1));
    for (int i = 0; i <= int'(v.len) && i < 4; i++)
      chk($sformatf("v%0d_word%0d", id, i), got_w[i], v.w[i]);
    chk($sformatf("v%0d_rises", id), 32'(rises - r0), v.rises + 32'(DUMMY_RISES));
    chk($sformatf("v%0d_csb_falls", id), 32'(csb_falls - f0), 32'd1);
    chk($sformatf("v%0d_gap", id), 32'(gap_cnt - g0), 32'(2 * CLK_DIV));
    chk($sformatf("v%0d_first_rise", id), 32'(first_rise_cyc - fall_cyc), 32'(CLK_DIV));
    chk($sformatf("v%0d_rdv_lat", id), 32'(rdv_cyc - last_rise_cyc), 32'd1);
  endtask

  initial begin
    int r0, t;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;

    vecs[0] = '{addr: 24'h000013, len: 8'd0, exp_addr: 24'h000010,
                w: {32'h0, 32'h0, 32'h0, 32'h44332211}, rises: 32'd64};
    vecs[1] = '{addr: 24'h000000, len: 8'd3, exp_addr: 24'h000000,
                w: {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100}, rises: 32'd160};
    vecs[2] = '{addr: 24'h000020, len: 8'd1, exp_addr: 24'h000020,
                w: {32'h0, 32'h0, 32'h27262524, 32'h23222120}, rises: 32'd96};
    vecs[3] = '{addr: 24'h0000FE, len: 8'd0, exp_addr: 24'h0000FC,
                w: {32'h0, 32'h0, 32'h0, 32'hFFFEFDFC}, rises: 32'd64};
    vecs[4] = '{addr: 24'hABCD47, len: 8'd0, exp_addr: 24'hABCD44,
                w: {32'h0, 32'h0, 32'h0, 32'h47464544}, rises: 32'd64};
    v20     = '{addr: 24'h000020, len: 8'd0, exp_addr: 24'h000020,
                w: {32'h0, 32'h0, 32'h0, 32'h23222120}, rises: 32'd64};

    // Reset state
    repeat (2) @(negedge ap_clk);
    chk("reset_outs", {26'd0, csb, spiclk, io0, rd_valid, req_ready, busy}, 32'b100010);
    chk("reset_data", rd_data, 32'd0);
    ap_rst = 1'b0;
    repeat (2) @(negedge ap_clk);

    for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

    // Backpressure: second word completes while the first is still unread
    r0 = rises;
    rd_ready = 1'b0;
    start_req(24'h000000, 8'd1);
    t = 0;
    while (!rd_valid && t < 2000) begin
      @(negedge ap_clk);
      t++;
    end
    chk("bp_first_valid", {31'd0, rd_valid}, 32'd1);
    repeat (200) @(negedge ap_clk);
    chk("bp_rises_frozen", 32'(rises - r0), 32'(96 + DUMMY_RISES));
    chk("bp_spiclk_low", {31'd0, spiclk}, 32'd0);
    chk("bp_csb_low", {31'd0, csb}, 32'd0);
    chk("bp_hold_word", rd_data, 32'h03020100);
    rd_ready = 1'b1;
    collect(2, 500);
    chk("bp_nwords", 32'(got_n), 32'd2);
    chk("bp_word0", got_w[0], 32'h03020100);
    chk("bp_word1", got_w[1], 32'h07060504);
    chk("bp_rises_total", 32'(rises - r0), 32'(96 + DUMMY_RISES));

    // Reset in the middle of a data phase, then a clean read
    rd_ready = 1'b1;
    r0 = rises;
    start_req(24'h000000, 8'd3);
    t = 0;
    while ((rises - r0) < 50 && t < 2000) begin
      @(negedge ap_clk);
      t++;
    end
    @(posedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    chk("midrst_outs", {26'd0, csb, spiclk, io0, rd_valid, req_ready, busy}, 32'b100010);
    chk("midrst_data", rd_data, 32'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    repeat (3) @(negedge ap_clk);
    run_vec(v20, 20);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
